// File: rtl/io_ctrl.sv
// Sequenced I/O controller: three-cycle CPU access FSM with stall, LED registers,
// debounced switches/button and a read-to-clear check flag.
module io_ctrl #(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int CNT_W           = 20
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        io_read,
  input  logic        io_write,
  input  logic [7:0]  addr,
  input  logic [15:0] wdata,
  output logic [15:0] rdata,
  output logic        io_ack,
  output logic        stall,
  output logic        bad_addr,
  input  logic [15:0] switch_in,
  input  logic        btn_check,
  output logic [23:0] led
);

  // state | meaning
  // IDLE  | waiting for io_read/io_write, latches addr/wdata/op
  // BUSY  | performs the LED write or the read capture
  // DONE  | io_ack/bad_addr asserted for one cycle, requests ignored
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  localparam logic [CNT_W-1:0] TC = CNT_W'(DEBOUNCE_CYCLES - 1);

  state_t      state;
  logic        op_rd;
  logic [7:0]  addr_q;
  logic [15:0] wdata_q;
  logic [15:0] rd_mux;
  logic        mapped;

  logic [15:0] sw_meta, sw_sync, sw_stable;
  logic [CNT_W-1:0] sw_cnt;
  logic        btn_meta, btn_sync, btn_stable;
  logic [CNT_W-1:0] btn_cnt;
  logic        check_flag;
  logic        btn_rise;
  logic        chk_clr;

  assign stall = (state == IDLE && (io_read || io_write)) || state == BUSY;

  always_comb begin
    rd_mux = 16'h0000;
    mapped = 1'b1;
    case (addr_q)
      8'h60:   rd_mux = {8'h00, led[23:16]};
      8'h62:   rd_mux = led[15:0];
      8'h70:   rd_mux = sw_stable;
      8'h20:   rd_mux = {15'b0, check_flag};
      default: mapped = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      op_rd    <= 1'b0;
      addr_q   <= 8'h00;
      wdata_q  <= 16'h0000;
      rdata    <= 16'h0000;
      io_ack   <= 1'b0;
      bad_addr <= 1'b0;
      led      <= 24'h000000;
    end else begin
      io_ack   <= 1'b0;
      bad_addr <= 1'b0;
      case (state)
        IDLE: begin
          if (io_read || io_write) begin
            op_rd   <= io_read;
            addr_q  <= addr;
            wdata_q <= wdata;
            state   <= BUSY;
          end
        end
        BUSY: begin
          if (op_rd) begin
            rdata <= rd_mux;
          end else if (addr_q == 8'h60) begin
            led[23:16] <= wdata_q[7:0];
          end else if (addr_q == 8'h62) begin
            led[15:0] <= wdata_q;
          end
          io_ack   <= 1'b1;
          bad_addr <= ~mapped;
          state    <= DONE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // The counter only runs while synced differs from stable, so hitting TC
  // with the button synced high is exactly the debounced rising edge.
  assign btn_rise = (btn_cnt == TC) && btn_sync;
  assign chk_clr  = (state == BUSY) && op_rd && (addr_q == 8'h20);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sw_meta    <= 16'h0000;
      sw_sync    <= 16'h0000;
      sw_stable  <= 16'h0000;
      sw_cnt     <= '0;
      btn_meta   <= 1'b0;
      btn_sync   <= 1'b0;
      btn_stable <= 1'b0;
      btn_cnt    <= '0;
      check_flag <= 1'b0;
    end else begin
      sw_meta  <= switch_in;
      sw_sync  <= sw_meta;
      btn_meta <= btn_check;
      btn_sync <= btn_meta;

      if (sw_sync == sw_stable) begin
        sw_cnt <= '0;
      end else if (sw_cnt == TC) begin
        sw_stable <= sw_sync;
        sw_cnt    <= '0;
      end else begin
        sw_cnt <= sw_cnt + 1'b1;
      end

      if (btn_sync == btn_stable) begin
        btn_cnt <= '0;
      end else if (btn_cnt == TC) begin
        btn_stable <= btn_sync;
        btn_cnt    <= '0;
      end else begin
        btn_cnt <= btn_cnt + 1'b1;
      end

      if (btn_rise) begin
        check_flag <= 1'b1;
      end else if (chk_clr) begin
        check_flag <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_io_ctrl.sv
// Directed bench for io_ctrl with a short debounce window.
module tb_io_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        io_read = 1'b0;
  logic        io_write = 1'b0;
  logic [7:0]  addr = 8'h00;
  logic [15:0] wdata = 16'h0000;
  logic [15:0] rdata;
  logic        io_ack;
  logic        stall;
  logic        bad_addr;
  logic [15:0] switch_in = 16'h0000;
  logic        btn_check = 1'b0;
  logic [23:0] led;

  int total = 0;
  int n_bad = 0;

  io_ctrl #(.DEBOUNCE_CYCLES(4), .CNT_W(2)) dut (
    .clk(clk), .rst_n(rst_n), .io_read(io_read), .io_write(io_write),
    .addr(addr), .wdata(wdata), .rdata(rdata), .io_ack(io_ack),
    .stall(stall), .bad_addr(bad_addr), .switch_in(switch_in),
    .btn_check(btn_check), .led(led)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Entered and left 1ns after a rising edge; covers cycles T..T+3.
  task automatic access(input string tag, input logic rd, input logic wr,
                        input logic [7:0] a, input logic [15:0] d,
                        input logic chk_data, input logic [15:0] exp_rd,
                        input logic exp_bad);
    io_read = rd; io_write = wr; addr = a; wdata = d;
    #1;
    chk({tag, " stall_T"}, stall, 1'b1);
    step(1);
    addr = 8'hEE; wdata = 16'hDEAD;
    chk({tag, " stall_T1"}, stall, 1'b1);
    chk({tag, " ack_T1"}, io_ack, 1'b0);
    step(1);
    chk({tag, " ack_T2"}, io_ack, 1'b1);
    chk({tag, " stall_T2"}, stall, 1'b0);
    chk({tag, " bad_T2"}, bad_addr, exp_bad);
    if (chk_data) chk({tag, " rdata"}, rdata, exp_rd);
    io_read = 1'b0; io_write = 1'b0;
    step(1);
    chk({tag, " ack_T3"}, io_ack, 1'b0);
  endtask

  initial begin
    step(2);
    chk("rst led", led, 24'h0);
    chk("rst rdata", rdata, 16'h0);
    chk("rst ack", io_ack, 1'b0);
    chk("rst bad", bad_addr, 1'b0);
    chk("rst stall", stall, 1'b0);
    rst_n = 1'b1;
    step(2);

    access("wr62", 1'b0, 1'b1, 8'h62, 16'hA5C3, 1'b0, 16'h0, 1'b0);
    chk("led after wr62", led, 24'h00A5C3);
    access("wr60", 1'b0, 1'b1, 8'h60, 16'h12FF, 1'b0, 16'h0, 1'b0);
    chk("led after wr60", led, 24'hFFA5C3);
    access("rd60", 1'b1, 1'b0, 8'h60, 16'h0, 1'b1, 16'h00FF, 1'b0);

    switch_in = 16'h8001;
    step(8);
    access("rd70", 1'b1, 1'b0, 8'h70, 16'h0, 1'b1, 16'h8001, 1'b0);
    switch_in = 16'hFFFF;
    step(2);
    switch_in = 16'h8001;
    step(1);
    access("rd70 glitch", 1'b1, 1'b0, 8'h70, 16'h0, 1'b1, 16'h8001, 1'b0);
    step(4);
    access("rd70 settled", 1'b1, 1'b0, 8'h70, 16'h0, 1'b1, 16'h8001, 1'b0);

    access("rd20 idle", 1'b1, 1'b0, 8'h20, 16'h0, 1'b1, 16'h0000, 1'b0);
    btn_check = 1'b1;
    step(8);
    btn_check = 1'b0;
    access("rd20 set", 1'b1, 1'b0, 8'h20, 16'h0, 1'b1, 16'h0001, 1'b0);
    access("rd20 clr", 1'b1, 1'b0, 8'h20, 16'h0, 1'b1, 16'h0000, 1'b0);

    access("rd44", 1'b1, 1'b0, 8'h44, 16'h0, 1'b1, 16'h0000, 1'b1);
    access("wr70", 1'b0, 1'b1, 8'h70, 16'hFFFF, 1'b1, 16'h0000, 1'b0);
    chk("led after wr70", led, 24'hFFA5C3);
    access("wr20", 1'b0, 1'b1, 8'h20, 16'hFFFF, 1'b0, 16'h0, 1'b0);
    access("wr99", 1'b0, 1'b1, 8'h99, 16'h1234, 1'b0, 16'h0, 1'b1);
    chk("led after wr99", led, 24'hFFA5C3);

    // Both requests held high through DONE: read wins, one ack, re-accept at T+3.
    io_read = 1'b1; io_write = 1'b1; addr = 8'h62; wdata = 16'h0F0F;
    step(2);
    chk("both ack_T2", io_ack, 1'b1);
    chk("both rdata", rdata, 16'hA5C3);
    chk("both stall_T2", stall, 1'b0);
    step(1);
    chk("both ack_T3", io_ack, 1'b0);
    chk("both stall_T3", stall, 1'b1);
    chk("both led", led, 24'hFFA5C3);
    step(1);
    chk("both stall_T4", stall, 1'b1);
    io_read = 1'b0; io_write = 1'b0;
    step(1);
    chk("both ack_T5", io_ack, 1'b1);
    step(1);
    chk("both ack_T6", io_ack, 1'b0);

    io_write = 1'b1; addr = 8'h62; wdata = 16'h00FF;
    step(1);
    chk("rstbusy stall", stall, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("rstbusy led", led, 24'h0);
    chk("rstbusy ack", io_ack, 1'b0);
    io_write = 1'b0;
    #1;
    chk("rstbusy stall_drop", stall, 1'b0);
    step(1);
    rst_n = 1'b1;
    step(3);
    chk("rstbusy ack_after", io_ack, 1'b0);
    chk("rstbusy led_after", led, 24'h0);
    chk("rstbusy idle", stall, 1'b0);
    access("post rst rd62", 1'b1, 1'b0, 8'h62, 16'h0, 1'b1, 16'h0000, 1'b0);

    $display("test done: total=%0d bad=%0d", total, n_bad);
    $finish;
  end

endmodule

// File: doc/io_ctrl.md
# io_ctrl

Sequenced memory-mapped I/O controller between the CPU's I/O port (the `ioRead`/`ioWrite` path) and the board peripherals. It turns each CPU I/O access into a fixed three-cycle transaction with a stall handshake. It owns the LED output registers, synchronises and debounces the switches and the check button, and holds a read-to-clear check flag.

## Interface

Parameters:
- DEBOUNCE_CYCLES, 1_000_000, cycles an input must stay stable before the debounced value updates (≥2).
- CNT_W, 20, debounce counter width; must hold DEBOUNCE_CYCLES-1.

Ports:
- clk  in  1  system clock; all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- io_read  in  1  CPU I/O read request; held while stall=1.
- io_write  in  1  CPU I/O write request; held while stall=1; io_read has priority if both are high.
- addr  in  8  low byte of the ALU address.
- wdata  in  16  write data, low half of the register-file operand.
- rdata  out  16  read data; valid when io_ack=1.
- io_ack  out  1  one-cycle transaction-complete pulse.
- stall  out  1  freezes the CPU PC/pipeline while high.
- bad_addr  out  1  pulses with io_ack when the address is unmapped.
- switch_in  in  16  raw board switches (asynchronous).
- btn_check  in  1  raw check button (asynchronous).
- led  out  24  LED drive; [15:0] LED_LOW, [23:16] LED_HIGH.

## Operation

Register map (addr):
- 0x60 LED_HIGH, R/W: a write takes wdata[7:0] into led[23:16]; a read returns {8'h0, led[23:16]}.
- 0x62 LED_LOW, R/W: a write takes wdata[15:0] into led[15:0]; a read returns led[15:0].
- 0x70 SWITCH, RO: a read returns the debounced switches; a write is ignored with no bad_addr.
- 0x20 CHECK, RO: a read returns {15'b0, check_flag} and clears the flag; a write is ignored with no bad_addr.
- Any other address: a read returns 16'h0000, a write is ignored, and bad_addr=1 with io_ack.

FSM with states IDLE, BUSY, DONE:
- IDLE: if io_read|io_write, latch addr, wdata and op (read wins), then go to BUSY. Otherwise stay in IDLE.
- BUSY: execute the access.
  - A write updates the LED register.
  - A read captures the selected value into the rdata register, and applies the CHECK clear.
  - Then go to DONE.
- DONE: io_ack=1 and bad_addr valid. Requests are ignored in this state. Return to IDLE.

stall = (state==IDLE && (io_read|io_write)) || state==BUSY. This is combinational, so the CPU freezes in the same cycle it issues the request.

Input conditioning, separate for the switch vector and for the button:
- Two-flop synchroniser.
- Then one shared counter per input group:
  - If synced == stable, the counter resets to 0.
  - Otherwise the counter increments.
  - When the counter reaches DEBOUNCE_CYCLES-1, stable <= synced and the counter clears.
- A rising edge of the debounced button sets check_flag.
- If a set and a CHECK-read clear happen in the same cycle, the set wins: the flag stays 1. The read that cycle returns the pre-clear value.

## Timing

- Reset (asynchronous, any state): state=IDLE; led=0, rdata=0, io_ack=0, bad_addr=0, check_flag=0. Debounced values, synchronisers and counters all go to 0. stall follows its equation, so it is 0 unless a request is present. An in-flight access is dropped with no ack and no LED update.
- Request at cycle T (IDLE):
  - stall=1 in T and T+1.
  - LED updates at the T+1→T+2 edge.
  - io_ack=1, rdata valid and stall=0 in T+2.
  - The earliest next acceptance is T+3.
  - Latency is 3 cycles per access, with 2 stall cycles.
- rdata holds its value after io_ack until the next read completes; writes leave rdata unchanged.
- The SWITCH read value is sampled in BUSY.
- Input to debounced latency is 2 sync cycles plus DEBOUNCE_CYCLES cycles of stability.
- A glitch shorter than DEBOUNCE_CYCLES restarts the count and never propagates.
- Changing addr or wdata during BUSY or DONE has no effect, because both are latched in IDLE.

## Test plan

- Reset, then write 0x62 with wdata=16'hA5C3: stall high for 2 cycles, io_ack at T+2, led=24'h00A5C3. Then write 0x60 with 16'h12FF: led=24'hFFA5C3.
- With DEBOUNCE_CYCLES=4: set switch_in=16'h8001 and hold ≥6 cycles, then read 0x70: rdata=16'h8001. A 2-cycle pulse to 16'hFFFF followed by a read: rdata stays 16'h8001.
- Press btn_check long enough to debounce, then read 0x20: rdata=16'h0001. An immediate second read: rdata=16'h0000.
- Read 0x44: io_ack=1, bad_addr=1, rdata=0. Write 0x70 with 16'hFFFF: bad_addr=0, led unchanged.
- io_read and io_write high together at 0x62: treated as a read, led unchanged, rdata=led[15:0]. Keep the request held through DONE: exactly one io_ack, and a new access is accepted only at T+3.
- Assert rst_n=0 during BUSY of a write of 16'h00FF to 0x62: no io_ack, led=0, stall=0 once the request drops, FSM returns to IDLE.
